mult_share_arbiter: RTL and testbench

Shares one 8x8 unsigned Dadda multiplier datapath between NREQ requesters. Arbitration is round-robin. Operands and products are registered in a two-stage pipeline, and each result is returned with the ID of the requester that issued it. The block sits between the requesting engines and the team's combinational 8x8 multiplier, which it instantiates internally. It sustains one multiply per cycle with full output backpressure.

---
 rtl/mult_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin front end that time-shares one 8x8 unsigned
// multiplier across NREQ requesters. S1 registers operands and ID, the
// multiplier sits between S1 and S2, and S2 registers product and ID.
// Results come back in accept order with the requester ID attached.

// Combinational 8x8 unsigned multiplier. Written as a shift-add sum of
// partial products; synthesis builds the carry-save reduction tree.
module mult8x8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   // sum of the eight partial products, exact 16-bit result
   always_comb begin
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p + ({8'd0, a} << i);
      end
   end

endmodule

module mult_share_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              res_valid,
   output logic [IDW-1:0]    res_id,
   output logic [15:0]       res_product,
   input  logic              res_ready,
   output logic              idle
);

   logic [7:0]     a_arr [NREQ];
   logic [7:0]     b_arr [NREQ];

   logic           s1_v;
   logic [7:0]     s1_a;
   logic [7:0]     s1_b;
   logic [IDW-1:0] s1_id;

   logic           s2_v;
   logic [15:0]    s2_p;
   logic [IDW-1:0] s2_id;

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic           s2_free;
   logic           s1_adv;
   logic           accept;
   logic [15:0]    mul_p;

   // unpack the flat operand buses into per-requester lanes
   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign a_arr[i] = req_a[8*i +: 8];
      assign b_arr[i] = req_b[8*i +: 8];
   end

   // S2 can take new data when empty or draining; S1 when empty or S2 moves
   assign s2_free = !s2_v | res_ready;
   assign s1_adv  = !s1_v | s2_free;
   assign accept  = s1_adv & grant_valid;

   // round-robin search starting at ptr, first valid requester wins
   always_comb begin
      int idx_i;
      idx_i       = 0;
      grant_valid = 1'b0;
      grant_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_i = (int'(ptr) + k) % NREQ;
         if (!grant_valid && req_valid[idx_i]) begin
            grant_valid = 1'b1;
            grant_id    = IDW'(idx_i);
         end
      end
   end

   // pointer moves just past the winner, wrapping at NREQ
   assign ptr_nxt = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;

   // one-hot ready for the winner; forced low while reset is asserted
   always_comb begin
      req_ready = '0;
      if (accept && rst_n) req_ready[grant_id] = 1'b1;
   end

   mult8x8 u_mult (
      .a (s1_a),
      .b (s1_b),
      .p (mul_p)
   );

   // S1: capture the granted request, clear when nothing is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v  <= 1'b0;
         s1_a  <= '0;
         s1_b  <= '0;
         s1_id <= '0;
         ptr   <= '0;
      end else if (s1_adv) begin
         s1_v <= grant_valid;
         if (grant_valid) begin
            s1_a  <= a_arr[grant_id];
            s1_b  <= b_arr[grant_id];
            s1_id <= grant_id;
            ptr   <= ptr_nxt;
         end
      end
   end

   // S2: take the product from S1 whenever the output slot is free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v  <= 1'b0;
         s2_p  <= '0;
         s2_id <= '0;
      end else if (s2_free) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_p  <= mul_p;
            s2_id <= s1_id;
         end
      end
   end

   assign res_valid   = s2_v;
   assign res_id      = s2_id;
   assign res_product = s2_p;
   assign idle        = !s1_v & !s2_v;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomized checks for mult_share_arbiter (NREQ=4).
module tb_mult_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [15:0] res_product;
   logic        res_ready;
   logic        idle;

   int n_chk;
   int n_fail;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] p;
   } exp_t;

   exp_t q[$];

   mult_share_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .res_valid   (res_valid),
      .res_id      (res_id),
      .res_product (res_product),
      .res_ready   (res_ready),
      .idle        (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [1:0] id, input logic [15:0] p);
      chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      chk({tag, "_id"}, {30'd0, res_id}, {30'd0, id});
      chk({tag, "_prod"}, {16'd0, res_product}, {16'd0, p});
   endtask

   initial begin
      logic        m_s1v, m_s2v, m_s2free, m_s1adv, gv, acc;
      logic [1:0]  m_ptr, g, acc_g;
      logic [3:0]  exp_rr;
      logic [7:0]  av, bv;
      int          idx;
      exp_t        e;

      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b1;
      req_valid = 4'hF;

      // reset state, ready must stay low even with requests pending
      #1;
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_id", {30'd0, res_id}, 32'd0);
      chk("rst_prod", {16'd0, res_product}, 32'd0);
      chk("rst_idle", {31'd0, idle}, 32'd1);
      req_valid = '0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // single requester, 0xFF*0xFF
      req_a[15:8] = 8'hFF; req_b[15:8] = 8'hFF; req_valid = 4'b0010;
      #1 chk("single_rr", {28'd0, req_ready}, 32'b0010);
      @(negedge clk);
      req_valid = '0;
      chk("single_lat", {31'd0, res_valid}, 32'd0);
      chk("single_busy", {31'd0, idle}, 32'd0);
      @(negedge clk);
      chk_res("single", 2'd1, 16'hFE01);
      @(negedge clk);
      chk("single_drain", {31'd0, res_valid}, 32'd0);
      chk("single_idle", {31'd0, idle}, 32'd1);

      // operands a=i+1, b=0x10 from here on
      req_a = 32'h04030201; req_b = 32'h10101010;

      // fairness, ptr=2 with requesters 0 and 3
      req_valid = 4'b1001;
      #1 chk("fair_rr0", {28'd0, req_ready}, 32'b1000);
      @(negedge clk);
      #1 chk("fair_rr1", {28'd0, req_ready}, 32'b0001);
      @(negedge clk);
      #1 chk("fair_rr2", {28'd0, req_ready}, 32'b1000);
      chk_res("fair_r0", 2'd3, 16'h0040);
      @(negedge clk);
      req_valid = '0;
      chk_res("fair_r1", 2'd0, 16'h0010);
      @(negedge clk);
      chk_res("fair_r2", 2'd3, 16'h0040);
      @(negedge clk);
      chk("fair_idle", {31'd0, idle}, 32'd1);

      // all four valid: grants 0,1,2,3,0 at one per cycle
      for (int k = 0; k < 8; k++) begin
         req_valid = (k < 5) ? 4'hF : 4'h0;
         #1;
         if (k < 5) chk("rr_grant", {28'd0, req_ready}, 32'(1 << (k % 4)));
         if (k >= 2 && k < 7) chk_res("rr_res", 2'((k-2) % 4), 16'(((k-2) % 4 + 1) * 16));
         if (k == 7) chk("rr_idle", {31'd0, idle}, 32'd1);
         @(negedge clk);
      end

      // backpressure with requester 2 (ptr=1), res_ready low for 3 cycles
      res_ready = 1'b0;
      req_a[23:16] = 8'd1; req_valid = 4'b0100;
      #1 chk("bp_rr0", {28'd0, req_ready}, 32'b0100);
      @(negedge clk);
      req_a[23:16] = 8'd2;
      #1 chk("bp_rr1", {28'd0, req_ready}, 32'b0100);
      chk("bp_v1", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      req_a[23:16] = 8'd3;
      for (int j = 0; j < 3; j++) begin
         #1 chk("bp_hold_rr", {28'd0, req_ready}, 32'd0);
         chk_res("bp_hold", 2'd2, 16'h0010);
         if (j < 2) @(negedge clk);
      end
      res_ready = 1'b1;
      #1 chk("bp_rel_rr", {28'd0, req_ready}, 32'b0100);
      @(negedge clk);
      req_a[23:16] = 8'd4;
      chk_res("bp_r1", 2'd2, 16'h0020);
      #1 chk("bp_rr4", {28'd0, req_ready}, 32'b0100);
      @(negedge clk);
      req_valid = '0;
      chk_res("bp_r2", 2'd2, 16'h0030);
      @(negedge clk);
      chk_res("bp_r3", 2'd2, 16'h0040);
      @(negedge clk);
      chk("bp_idle", {31'd0, idle}, 32'd1);
      req_a[23:16] = 8'd3;

      // reset with both stages full (ptr=3)
      res_ready = 1'b0; req_valid = 4'hF;
      #1 chk("mr_rr0", {28'd0, req_ready}, 32'b1000);
      @(negedge clk);
      #1 chk("mr_rr1", {28'd0, req_ready}, 32'b0001);
      @(negedge clk);
      chk("mr_full_rr", {28'd0, req_ready}, 32'd0);
      chk_res("mr_full", 2'd3, 16'h0040);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_valid", {31'd0, res_valid}, 32'd0);
      chk("mr_rr", {28'd0, req_ready}, 32'd0);
      chk("mr_idle", {31'd0, idle}, 32'd1);
      chk("mr_prod", {16'd0, res_product}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; req_valid = 4'b0110; res_ready = 1'b1;
      #1 chk("mr_first", {28'd0, req_ready}, 32'b0010);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      chk_res("mr_res", 2'd1, 16'h0020);
      @(negedge clk);
      chk("mr_idle2", {31'd0, idle}, 32'd1);

      // random traffic against a reference pipeline model (ptr=2, empty)
      m_s1v = 1'b0; m_s2v = 1'b0; m_ptr = 2'd2; acc = 1'b0; acc_g = '0;
      for (int c = 0; c < 3004; c++) begin
         if (acc) req_valid[acc_g] = 1'b0;
         if (c < 3000) begin
            for (int i = 0; i < 4; i++) begin
               if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                  av = 8'($urandom_range(0, 255));
                  bv = 8'($urandom_range(0, 255));
                  req_a[8*i +: 8] = av;
                  req_b[8*i +: 8] = bv;
                  req_valid[i] = 1'b1;
               end
            end
            res_ready = ($urandom_range(0, 3) != 0);
         end else begin
            req_valid = '0;
            res_ready = 1'b1;
         end
         #1;
         m_s2free = !m_s2v | res_ready;
         m_s1adv  = !m_s1v | m_s2free;
         gv = 1'b0; g = '0;
         for (int k = 0; k < 4; k++) begin
            idx = (int'(m_ptr) + k) % 4;
            if (!gv && req_valid[idx]) begin gv = 1'b1; g = 2'(idx); end
         end
         exp_rr = '0;
         if (gv && m_s1adv) exp_rr[g] = 1'b1;
         chk("rnd_rr", {28'd0, req_ready}, {28'd0, exp_rr});
         chk("rnd_valid", {31'd0, res_valid}, {31'd0, m_s2v});
         if (m_s2v && q.size() > 0) begin
            chk("rnd_id", {30'd0, res_id}, {30'd0, q[0].id});
            chk("rnd_prod", {16'd0, res_product}, {16'd0, q[0].p});
            if (res_ready) void'(q.pop_front());
         end
         acc = gv && m_s1adv;
         if (acc) begin
            e.id = g;
            e.p  = 16'(req_a[8*g +: 8]) * 16'(req_b[8*g +: 8]);
            q.push_back(e);
            acc_g = g;
            m_ptr = g + 2'd1;
         end
         if (m_s2free) m_s2v = m_s1v;
         if (m_s1adv)  m_s1v = gv;
         @(negedge clk);
      end
      chk("rnd_drained", 32'(q.size()), 32'd0);
      chk("rnd_idle", {31'd0, idle}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
